// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : shared types and widths for the Wishbone master adapter
// Rev 1.0
// ============================================================================
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // Loads always fetch the full word; stores honour the core byte enables.
  function automatic logic [WB_SEL_W-1:0] wb_sel_for(input logic we,
                                                     input logic [WB_SEL_W-1:0] be);
    return we ? be : {WB_SEL_W{1'b1}};
  endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// ============================================================================
// wb_timeout_counter : counts response-less bus cycles, flags the last one
// Rev 1.0
// ============================================================================
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted during the TIMEOUT_CYCLES-th bus cycle so the abort lands on its closing edge.
  assign expired_o = enable_i && (count_q == C_LAST);

endmodule : wb_timeout_counter
`default_nettype wire

// File: rtl/wishbone_master_adapter_core.sv
`default_nettype none
// ============================================================================
// wishbone_master_adapter_core : single-outstanding core load/store to Wishbone classic
// Rev 1.0
// ============================================================================
module wishbone_master_adapter_core
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 core_req_i,
  input  logic                 core_we_i,
  input  logic [WB_ADDR_W-1:0] core_addr_i,
  input  logic [WB_DATA_W-1:0] core_wdata_i,
  input  logic [WB_SEL_W-1:0]  core_be_i,
  output logic                 core_stall_o,
  output logic [WB_DATA_W-1:0] core_rdata_o,
  output logic                 core_done_o,
  output logic                 core_err_o,
  output logic [WB_ADDR_W-1:0] wb_addr_o,
  output logic [WB_DATA_W-1:0] wb_data_o,
  output logic [WB_SEL_W-1:0]  wb_sel_o,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  input  logic [WB_DATA_W-1:0] wb_data_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i
);

  wb_state_e            state_q, state_d;
  logic [WB_ADDR_W-1:0] addr_q, addr_d;
  logic [WB_DATA_W-1:0] wdata_q, wdata_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic                 we_q, we_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic [WB_DATA_W-1:0] rdata_q, rdata_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 tmo_expired;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q != ST_BUS),
    .enable_i (state_q == ST_BUS),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (core_req_i) begin
          addr_d  = core_addr_i;
          wdata_d = core_wdata_i;
          we_d    = core_we_i;
          sel_d   = wb_sel_for(core_we_i, core_be_i);
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // Error and timeout take priority over a coincident ack; read data is then discarded.
        if (wb_err_i || tmo_expired) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (wb_ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_RESP;
          if (!we_q) begin
            rdata_d = wb_data_i;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign core_stall_o = (state_q == ST_BUS) || ((state_q == ST_IDLE) && core_req_i);
  assign core_rdata_o = rdata_q;
  assign core_done_o  = done_q;
  assign core_err_o   = err_q;
  assign wb_addr_o    = addr_q;
  assign wb_data_o    = wdata_q;
  assign wb_sel_o     = sel_q;
  assign wb_we_o      = we_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;

endmodule : wishbone_master_adapter_core
`default_nettype wire

// File: tb/tb_wishbone_master_adapter_core.sv
`default_nettype none
// ============================================================================
// tb_wishbone_master_adapter_core : directed self-checking bench, timeout set to 8
// Rev 1.0
// ============================================================================
module tb_wishbone_master_adapter_core;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [3:0]  core_be_i;
  logic        core_stall_o;
  logic [31:0] core_rdata_o;
  logic        core_done_o;
  logic        core_err_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int passes = 0;
  int total  = 0;

  wishbone_master_adapter_core #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .core_req_i  (core_req_i),
    .core_we_i   (core_we_i),
    .core_addr_i (core_addr_i),
    .core_wdata_i(core_wdata_i),
    .core_be_i   (core_be_i),
    .core_stall_o(core_stall_o),
    .core_rdata_o(core_rdata_o),
    .core_done_o (core_done_o),
    .core_err_o  (core_err_o),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_sel_o    (wb_sel_o),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_data_i   (wb_data_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst_i        = 1'b1;
    core_req_i   = 1'b0;
    core_we_i    = 1'b0;
    core_addr_i  = '0;
    core_wdata_i = '0;
    core_be_i    = '0;
    wb_data_i    = '0;
    wb_ack_i     = 1'b0;
    wb_err_i     = 1'b0;
    tick();
    tick();
    check("rst_cyc",   {31'd0, wb_cyc_o},    32'd0);
    check("rst_stb",   {31'd0, wb_stb_o},    32'd0);
    check("rst_sel",   {28'd0, wb_sel_o},    32'd0);
    check("rst_addr",  wb_addr_o,            32'd0);
    check("rst_rdata", core_rdata_o,         32'd0);
    check("rst_done",  {31'd0, core_done_o}, 32'd0);
    check("rst_stall", {31'd0, core_stall_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // Load with a one-cycle-ack slave
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_addr_i = 32'h1000_0004;
    core_be_i   = 4'b0010;
    #1;
    check("ld_stall_idle", {31'd0, core_stall_o}, 32'd1);
    tick();
    check("ld_cyc", {31'd0, wb_cyc_o}, 32'd1);
    check("ld_stb", {31'd0, wb_stb_o}, 32'd1);
    check("ld_sel", {28'd0, wb_sel_o}, 32'hF);
    check("ld_we",  {31'd0, wb_we_o},  32'd0);
    check("ld_addr", wb_addr_o, 32'h1000_0004);
    tick();
    check("ld_cyc_hold", {31'd0, wb_cyc_o}, 32'd1);
    check("ld_no_done",  {31'd0, core_done_o}, 32'd0);
    wb_ack_i  = 1'b1;
    wb_data_i = 32'hDEAD_BEEF;
    tick();
    check("ld_done",  {31'd0, core_done_o},  32'd1);
    check("ld_err",   {31'd0, core_err_o},   32'd0);
    check("ld_cyc_off", {31'd0, wb_cyc_o},   32'd0);
    check("ld_rdata", core_rdata_o,          32'hDEAD_BEEF);
    check("ld_stall_resp", {31'd0, core_stall_o}, 32'd0);
    wb_ack_i   = 1'b0;
    core_req_i = 1'b0;
    tick();
    check("ld_done_pulse", {31'd0, core_done_o}, 32'd0);

    // Store, ack delayed five cycles
    core_req_i   = 1'b1;
    core_we_i    = 1'b1;
    core_addr_i  = 32'h1000_0000;
    core_wdata_i = 32'h0000_0041;
    core_be_i    = 4'b0001;
    tick();
    core_addr_i  = 32'hFFFF_FFFF;
    core_wdata_i = 32'hFFFF_FFFF;
    core_be_i    = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      check("st_stb",  {31'd0, wb_stb_o}, 32'd1);
      check("st_addr", wb_addr_o, 32'h1000_0000);
      check("st_data", wb_data_o, 32'h0000_0041);
      check("st_sel",  {28'd0, wb_sel_o}, 32'h1);
      check("st_we",   {31'd0, wb_we_o},  32'd1);
      check("st_no_done", {31'd0, core_done_o}, 32'd0);
      tick();
    end
    wb_ack_i  = 1'b1;
    wb_data_i = 32'h5555_AAAA;
    tick();
    check("st_done",  {31'd0, core_done_o}, 32'd1);
    check("st_err",   {31'd0, core_err_o},  32'd0);
    check("st_rdata", core_rdata_o, 32'hDEAD_BEEF);
    wb_ack_i   = 1'b0;
    core_req_i = 1'b0;
    tick();

    // Timeout after eight silent bus cycles
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_addr_i = 32'h2000_0000;
    wb_data_i   = 32'h0BAD_0BAD;
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_cyc_hold", {31'd0, wb_cyc_o}, 32'd1);
      check("to_no_done",  {31'd0, core_done_o}, 32'd0);
    end
    tick();
    check("to_cyc_off", {31'd0, wb_cyc_o},    32'd0);
    check("to_stb_off", {31'd0, wb_stb_o},    32'd0);
    check("to_done",    {31'd0, core_done_o}, 32'd1);
    check("to_err",     {31'd0, core_err_o},  32'd1);
    check("to_rdata",   core_rdata_o, 32'hDEAD_BEEF);
    core_req_i = 1'b0;
    tick();
    check("to_err_pulse", {31'd0, core_err_o}, 32'd0);

    // Ack and err together: err wins
    core_req_i  = 1'b1;
    core_addr_i = 32'h3000_0008;
    tick();
    wb_ack_i  = 1'b1;
    wb_err_i  = 1'b1;
    wb_data_i = 32'h1234_5678;
    tick();
    check("ae_done",  {31'd0, core_done_o}, 32'd1);
    check("ae_err",   {31'd0, core_err_o},  32'd1);
    check("ae_rdata", core_rdata_o, 32'hDEAD_BEEF);
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    core_req_i = 1'b0;
    tick();

    // Back-to-back held requests
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_addr_i = 32'h4000_0000;
    tick();
    check("bb1_stb", {31'd0, wb_stb_o}, 32'd1);
    wb_ack_i  = 1'b1;
    wb_data_i = 32'h1111_1111;
    tick();
    check("bb1_done",  {31'd0, core_done_o}, 32'd1);
    check("bb1_rdata", core_rdata_o, 32'h1111_1111);
    check("bb_gap1",   {31'd0, wb_stb_o}, 32'd0);
    wb_ack_i    = 1'b0;
    core_addr_i = 32'h4000_0010;
    tick();
    check("bb_gap2",   {31'd0, wb_stb_o}, 32'd0);
    check("bb_resp_done_off", {31'd0, core_done_o}, 32'd0);
    tick();
    check("bb2_stb",  {31'd0, wb_stb_o}, 32'd1);
    check("bb2_addr", wb_addr_o, 32'h4000_0010);
    wb_ack_i  = 1'b1;
    wb_data_i = 32'h2222_2222;
    tick();
    check("bb2_done",  {31'd0, core_done_o}, 32'd1);
    check("bb2_rdata", core_rdata_o, 32'h2222_2222);
    wb_ack_i   = 1'b0;
    core_req_i = 1'b0;
    tick();

    // Asynchronous reset in the middle of a bus cycle
    core_req_i   = 1'b1;
    core_we_i    = 1'b1;
    core_addr_i  = 32'h5000_0000;
    core_wdata_i = 32'hCAFE_F00D;
    core_be_i    = 4'b1100;
    tick();
    check("rb_cyc", {31'd0, wb_cyc_o}, 32'd1);
    #2;
    rst_i      = 1'b1;
    core_req_i = 1'b0;
    #1;
    check("rb_cyc_async", {31'd0, wb_cyc_o}, 32'd0);
    check("rb_stb_async", {31'd0, wb_stb_o}, 32'd0);
    check("rb_done",      {31'd0, core_done_o}, 32'd0);
    tick();
    check("rb_rdata", core_rdata_o, 32'd0);
    rst_i = 1'b0;
    tick();
    check("rb_idle_done", {31'd0, core_done_o}, 32'd0);
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_addr_i = 32'h6000_0004;
    tick();
    check("rb_new_stb",  {31'd0, wb_stb_o}, 32'd1);
    check("rb_new_addr", wb_addr_o, 32'h6000_0004);
    check("rb_new_sel",  {28'd0, wb_sel_o}, 32'hF);
    wb_ack_i  = 1'b1;
    wb_data_i = 32'h7777_8888;
    tick();
    check("rb_new_done",  {31'd0, core_done_o}, 32'd1);
    check("rb_new_err",   {31'd0, core_err_o},  32'd0);
    check("rb_new_rdata", core_rdata_o, 32'h7777_8888);
    wb_ack_i   = 1'b0;
    core_req_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule : tb_wishbone_master_adapter_core
`default_nettype wire

// File: doc/wishbone_master_adapter_core.md
WISHBONE_MASTER_ADAPTER_CORE -- requirements
Module: wishbone_master_adapter_core

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of BUS-state cycles without wb_ack_i/wb_err_i before abort; legal range 1..65535.
REQ-002 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 core_req_i  input  1  core requests a load/store; held high until core_done_o.
REQ-005 core_we_i  input  1  1 = store, 0 = load.
REQ-006 core_addr_i  input  32  byte address.
REQ-007 core_wdata_i  input  32  store data.
REQ-008 core_be_i  input  4  store byte enables.
REQ-009 core_stall_o  output  1  core must hold pipeline.
REQ-010 core_rdata_o  output  32  last load data, registered.
REQ-011 core_done_o  output  1  one-cycle completion pulse.
REQ-012 core_err_o  output  1  one-cycle pulse coincident with core_done_o on bus error or timeout.
REQ-013 wb_addr_o  output  32;  wb_data_o  output  32;  wb_sel_o  output  4;  wb_we_o  output  1;  wb_cyc_o  output  1;  wb_stb_o  output  1 -- Wishbone classic master outputs, all registered.
REQ-014 wb_data_i  input  32;  wb_ack_i  input  1;  wb_err_i  input  1 -- Wishbone slave responses.

Function
REQ-015 FSM states IDLE, BUS, RESP shall be implemented; no other reachable states.
REQ-016 IDLE: core_req_i=1 at edge N shall latch addr/wdata/we into wb_* registers, set wb_sel_o = core_be_i for stores and 4'hF for loads, set wb_cyc_o=wb_stb_o=1 from cycle N+1, go to BUS.
REQ-017 BUS: wb_cyc_o, wb_stb_o, wb_addr_o, wb_data_o, wb_sel_o, wb_we_o shall stay constant until termination.
REQ-018 BUS: wb_ack_i=1 sampled at edge M shall clear cyc/stb at M+1, pulse core_done_o at M+1, go to RESP.
REQ-019 Load termination shall capture wb_data_i into core_rdata_o at edge M; stores shall leave core_rdata_o unchanged.
REQ-020 wb_err_i=1 (with or without wb_ack_i) shall terminate as REQ-018 plus core_err_o=1; core_rdata_o unchanged; err wins over simultaneous ack.
REQ-021 Timeout counter shall clear on BUS entry, increment each BUS cycle without response; on reaching TIMEOUT_CYCLES shall terminate as REQ-020.
REQ-022 RESP shall last exactly one cycle, then IDLE; core_req_i ignored in RESP, so back-to-back requests have stb low for at least 2 cycles (slave cooldown compatible).
REQ-023 core_stall_o = (state==BUS) or (state==IDLE and core_req_i); 0 in RESP.
REQ-024 Nominal latency with a one-cycle-ack slave: request edge N, stb N+1, ack N+2, done N+3, next stb no earlier than N+5.
REQ-025 core_done_o and core_err_o shall be registered, never high outside RESP.

Reset
REQ-026 rst_i shall force immediately: state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_addr_o=wb_data_o=0, core_rdata_o=0, core_done_o=core_err_o=0, counter 0.
REQ-027 Reset mid-BUS shall drop cyc/stb without done/err pulse; first post-reset request starts a fresh cycle.

Structure
REQ-028 Package wb_pkg shall hold the state enum, WB_ADDR_W=32, WB_DATA_W=32, WB_SEL_W=4.
REQ-029 Timeout shall be a sub-module wb_timeout_counter (inputs clear, enable; output expired; width $clog2(TIMEOUT_CYCLES+1)).

Verification
REQ-030 Load 0x1000_0004, slave acks 1 cycle after stb, data 0xDEAD_BEEF -> sel=4'hF, we=0, done at N+3, core_rdata_o=0xDEAD_BEEF.
REQ-031 Store 0x1000_0000, wdata 0x0000_0041, be 4'b0001, ack delayed 5 cycles -> wb_* stable throughout BUS, sel=4'b0001, done after ack, rdata unchanged.
REQ-032 No response, TIMEOUT_CYCLES=8 -> cyc/stb drop after 8 BUS cycles, done=err=1 same cycle.
REQ-033 ack and err high together -> core_err_o=1, rdata unchanged.
REQ-034 Two requests held back-to-back -> stb low for 2 cycles between them, both complete in order.
REQ-035 rst_i asserted mid-BUS -> cyc/stb low asynchronously, no done pulse, next request succeeds.
